// File: rtl/tmng_sequencer.sv
// Program sequencer for the time-multiplexed NAND core: expands each stored
// "dst = NAND(src_a, src_b)" instruction into a 4-cycle command pattern.
module tmng_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = 4,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [PC_W-1:0]       prog_addr,
  input  logic [3*ADDR_W-1:0]   prog_data,
  input  logic [PC_W:0]         len,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [PC_W-1:0]       pc,
  output logic [ADDR_W:0]       core_ui,
  output logic [ADDR_W:0]       core_uio
);

  // state   | meaning
  // IDLE    | waiting for start, command bytes parked at zero
  // PH_A    | drive src_a with mode=0 (operand A load)
  // PH_B    | drive src_b with mode=1 and commit=1 with dst (write)
  // PH_C    | drain, commit low
  // PH_D    | drain, re-arms the core's commit edge detector; advance or finish
  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

  localparam int INSTR_W = 3 * ADDR_W;
  localparam logic [PC_W:0] LEN_MAX = (PC_W + 1)'(PROG_DEPTH);

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W:0]        len_q, len_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_W:0]      ui_q, ui_d;
  logic [ADDR_W:0]      uio_q, uio_d;
  logic [PC_W:0]        len_eff;
  logic [PC_W:0]        pc_inc;
  logic [INSTR_W-1:0]   fetch;

  logic [INSTR_W-1:0]   mem_q [PROG_DEPTH];

  assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;
  assign pc_inc  = {1'b0, pc_q} + (PC_W + 1)'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    done_d  = 1'b0;
    ui_d    = '0;
    uio_d   = '0;
    fetch   = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_eff != '0) begin
            state_d = PH_A;
            pc_d    = '0;
            len_d   = len_eff;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PH_A: begin
        state_d = PH_B;
        ui_d    = {1'b1, instr_q[ADDR_W +: ADDR_W]};
        uio_d   = {1'b1, instr_q[0 +: ADDR_W]};
      end
      PH_B: state_d = PH_C;
      PH_C: state_d = PH_D;
      PH_D: begin
        if (pc_inc < len_q) begin
          state_d = PH_A;
          pc_d    = pc_inc[PC_W-1:0];
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Instruction is captured on PH_A entry so later writes cannot disturb it
    if (state_d == PH_A) begin
      fetch   = mem_q[pc_d];
      instr_d = fetch;
      ui_d    = {1'b0, fetch[2*ADDR_W +: ADDR_W]};
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ui_q    <= '0;
      uio_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
    end
  end

  // Program store is deliberately left out of reset so it survives rst
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pc       = pc_q;
  assign core_ui  = ui_q;
  assign core_uio = uio_q;

endmodule

// File: tb/tb_tmng_sequencer.sv
// Scoreboard bench for tmng_sequencer: expected per-cycle activity is queued
// at stimulus time and a negedge monitor pops and compares it.
module tb_tmng_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [20:0] prog_data;
  logic [4:0]  len;
  logic        start;
  logic        busy, done;
  logic [3:0]  pc;
  logic [7:0]  core_ui, core_uio;

  tmng_sequencer #(.PROG_DEPTH(16), .PC_W(4), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .len(len), .start(start), .busy(busy),
    .done(done), .pc(pc), .core_ui(core_ui), .core_uio(core_uio)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] ui;
    logic [7:0] uio;
    logic       busy;
    logic       done;
    logic [3:0] pc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [6:0] sa [16];
  logic [6:0] sb [16];
  logic [6:0] sd [16];
  logic [3:0] last_pc;
  int         t;

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal core model: 1-bit regfile, A latched in mode 0, NAND written
  // one cycle after a rising commit edge.
  logic       creg [128];
  logic       a_lat, commit_prev, wr_pend, wr_val;
  logic [6:0] wr_addr;
  always @(posedge clk) begin
    if (rst) begin
      creg[0] <= 1'b0;
      creg[1] <= 1'b1;
      commit_prev <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      if (!core_ui[7]) a_lat <= creg[core_ui[6:0]];
      commit_prev <= core_uio[7];
      if (core_ui[7] && core_uio[7] && !commit_prev) begin
        wr_pend <= 1'b1;
        wr_addr <= core_uio[6:0];
        wr_val  <= ~(a_lat & creg[core_ui[6:0]]);
      end else begin
        wr_pend <= 1'b0;
      end
      if (wr_pend) creg[wr_addr] <= wr_val;
    end
  end

  always @(negedge clk) begin
    if (mon_en && (busy || done || core_ui != 8'h00 || core_uio != 8'h00)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_activity cyc=%0d ui=%h uio=%h busy=%b done=%b pc=%0d",
                 cyc, core_ui, core_uio, busy, done, pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.ui !== core_ui || mon_e.uio !== core_uio ||
            mon_e.busy !== busy || mon_e.done !== done || mon_e.pc !== pc) begin
          n_bad++;
          $display("FAIL event got cyc=%0d ui=%h uio=%h busy=%b done=%b pc=%0d / expected cyc=%0d ui=%h uio=%h busy=%b done=%b pc=%0d",
                   cyc, core_ui, core_uio, busy, done, pc,
                   mon_e.cyc, mon_e.ui, mon_e.uio, mon_e.busy, mon_e.done, mon_e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_slot(input int s, input int a, input int b, input int d);
    prog_we   = 1'b1;
    prog_addr = 4'(s);
    prog_data = {7'(a), 7'(b), 7'(d)};
    sa[s] = 7'(a); sb[s] = 7'(b); sd[s] = 7'(d);
    step(1);
    prog_we = 1'b0;
  endtask

  // Queue up to ncut expected events for a run whose start is sampled in cycle t0
  task automatic push_run(input int t0, input int l, input int ncut);
    ev_t e;
    int  n = 0;
    for (int k = 0; k < l; k++) begin
      for (int p = 0; p < 4; p++) begin
        if (n < ncut) begin
          e.cyc  = t0 + 1 + 4*k + p;
          e.ui   = (p == 0) ? {1'b0, sa[k]} : (p == 1) ? {1'b1, sb[k]} : 8'h00;
          e.uio  = (p == 1) ? {1'b1, sd[k]} : 8'h00;
          e.busy = 1'b1;
          e.done = 1'b0;
          e.pc   = 4'(k);
          exp_q.push_back(e);
          n++;
        end
      end
    end
    if (n < ncut) begin
      if (l > 0) last_pc = 4'(l - 1);
      e.cyc = t0 + 4*l + 1; e.ui = 8'h00; e.uio = 8'h00;
      e.busy = 1'b0; e.done = 1'b1; e.pc = last_pc;
      exp_q.push_back(e);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l > 16) ? 16 : l;
  endfunction

  task automatic issue(input int l, input int ncut);
    start = 1'b1;
    len   = 5'(l);
    t     = cyc;
    push_run(t, eff_len(l), ncut);
  endtask

  task automatic run(input int l);
    issue(l, 1000);
    step(1);
    start = 1'b0;
    step(4*eff_len(l) + 3);
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    len = '0; start = 1'b0; last_pc = '0;
    step(2);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_core_ui", 32'(core_ui), 0);
    chk("reset_core_uio", 32'(core_uio), 0);
    step(1);

    // single instruction: expect 05/00, 89/83, 00/00, 00/00, then done
    load_slot(0, 5, 9, 3);
    run(1);

    // full program, len clamped to 16
    for (int s = 0; s < 16; s++) load_slot(s, s + 1, s + 20, s + 40);
    run(20);

    // len = 0: done next cycle, pc holds 15
    run(0);

    // start and prog_we while busy are both dropped
    issue(3, 1000);
    step(1);
    start = 1'b0;
    step(4);
    start = 1'b1; len = 5'd1;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = {7'h7f, 7'h7f, 7'h7f};
    step(1);
    prog_addr = 4'd2;
    step(1);
    start = 1'b0; prog_we = 1'b0;
    step(8);
    run(3);

    // start high in the done cycle is accepted
    issue(2, 1000);
    step(1);
    start = 1'b0;
    step(8);
    issue(1, 1000);
    step(1);
    start = 1'b0;
    step(6);

    // reset during PH_B of instruction 2
    issue(5, 10);
    step(1);
    start = 1'b0;
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    last_pc = 4'd0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_core_uio", 32'(core_uio), 0);
    step(3);
    run(1);

    // end-to-end NAND truth table against the core model
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    last_pc = 4'd0;
    step(1);
    load_slot(0, 0, 0, 10);
    load_slot(1, 0, 1, 11);
    load_slot(2, 1, 0, 12);
    load_slot(3, 1, 1, 13);
    run(4);
    step(2);
    chk("nand_00", 32'(creg[10]), 1);
    chk("nand_01", 32'(creg[11]), 1);
    chk("nand_10", 32'(creg[12]), 1);
    chk("nand_11", 32'(creg[13]), 0);

    step(5);
    chk("pending_events", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
